uart_tx_param: RTL and testbench

//   Parametrised UART transmitter; successor to the fixed 8N1 transmitter in the frequency-meter

---
 rtl/uart_tx_param.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, valid/ready push, configurable data width,
// parity and stop bits; all bit timing from an internal down-counter in the clk domain.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] RELOAD    = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head, shift;
  logic                 par_bit, head_par;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_idx;
  logic                 push, pop, bit_done, frame_end;

  assign head     = mem[rd_ptr];
  assign tx_ready = (fifo_cnt != CW'(FIFO_DEPTH));
  assign busy     = (state != IDLE) || (fifo_cnt != '0);

  // The next word is popped either from IDLE or on the last edge of the stop period,
  // which gives back-to-back frames with no idle gap.
  always_comb begin
    bit_done  = (timer == '0);
    frame_end = (state == STOP) && bit_done && (bit_idx == LAST_STOP);
    pop       = (fifo_cnt != '0) && ((state == IDLE) || frame_end);
    push      = tx_valid && tx_ready;
    head_par  = (PARITY == 1) ? ~^head : ^head;
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // NOTE: non-blocking assignments let every register sample the pre-edge values, so a
  // simultaneous push and pop see a consistent count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      TxD     <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TxD <= 1'b1;
          if (pop) begin
            state   <= START;
            TxD     <= 1'b0;
            timer   <= RELOAD;
            shift   <= head;
            par_bit <= head_par;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            TxD     <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            timer   <= RELOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= RELOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                TxD   <= par_bit;
              end else begin
                state <= STOP;
                TxD   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              TxD     <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PAR: begin
          if (bit_done) begin
            state   <= STOP;
            TxD     <= 1'b1;
            bit_idx <= '0;
            timer   <= RELOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer <= RELOAD;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              if (pop) begin
                state   <= START;
                TxD     <= 1'b0;
                shift   <= head;
                par_bit <= head_par;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations at CLKS_PER_BIT=4, frames decoded
// from TxD and compared against a scoreboard of frames modelled when each word is accepted.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [8:0] tdata [4];
  logic [3:0] tvalid = '0;
  wire  [3:0] txd, busy_w, rdy;
  wire  [2:0] cnt_w [4];

  logic [15:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tdata[0][7:0]), .tx_valid(tvalid[0]), .tx_ready(rdy[0]),
    .TxD(txd[0]), .busy(busy_w[0]), .fifo_cnt(cnt_w[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tdata[1][7:0]), .tx_valid(tvalid[1]), .tx_ready(rdy[1]),
    .TxD(txd[1]), .busy(busy_w[1]), .fifo_cnt(cnt_w[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tdata[2][7:0]), .tx_valid(tvalid[2]), .tx_ready(rdy[2]),
    .TxD(txd[2]), .busy(busy_w[2]), .fifo_cnt(cnt_w[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tdata[3][6:0]), .tx_valid(tvalid[3]), .tx_ready(rdy[3]),
    .TxD(txd[3]), .busy(busy_w[3]), .fifo_cnt(cnt_w[3]));

  function automatic int f_db(input int idx);
    return (idx == 3) ? 7 : 8;
  endfunction
  function automatic int f_par(input int idx);
    return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
  endfunction
  function automatic int f_sb(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction
  function automatic int f_len(input int idx);
    return 1 + f_db(idx) + ((f_par(idx) != 0) ? 1 : 0) + f_sb(idx);
  endfunction

  // Line bits in transmission order: bit 0 is the start bit.
  function automatic logic [15:0] make_frame(input int idx, input logic [8:0] d);
    logic [15:0] f = '0;
    int ones = 0;
    int pos;
    for (int i = 0; i < f_db(idx); i++) begin
      f[1 + i] = d[i];
      ones += int'(d[i]);
    end
    pos = 1 + f_db(idx);
    if (f_par(idx) == 2) begin f[pos] = ((ones % 2) == 1); pos++; end
    if (f_par(idx) == 1) begin f[pos] = ((ones % 2) == 0); pos++; end
    for (int s = 0; s < f_sb(idx); s++) f[pos + s] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; leaves tx_valid high and returns at the negedge after acceptance.
  task automatic push_word(input int idx, input logic [8:0] d, output int pcyc);
    int n = 0;
    tdata[idx]  = d;
    tvalid[idx] = 1'b1;
    pcyc = 0;
    while (!rdy[idx] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[idx]) begin
      check("push_timeout", {31'b0, rdy[idx]}, 1);
      return;
    end
    @(posedge clk);
    sb.push_back(make_frame(idx, d));
    @(negedge clk);
    pcyc = cyc;
  endtask

  task automatic recv_and_score(input int idx, output logic [15:0] bits, output int scyc);
    int n = 0;
    bits = '0;
    scyc = 0;
    @(negedge clk);
    while (txd[idx] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (txd[idx] !== 1'b0) begin
      check("start_timeout", {31'b0, txd[idx]}, 0);
      return;
    end
    scyc = cyc;
    for (int k = 0; k < f_len(idx); k++) begin
      repeat ((k == 0) ? 2 : CPB) @(negedge clk);
      bits[k] = txd[idx];
    end
    if (sb.size() == 0) check("unexpected_frame", 32'(sb.size()), 1);
    else check("frame", {16'b0, bits}, {16'b0, sb.pop_front()});
  endtask

  task automatic check_end(input int idx, input int scyc, input int len);
    while (cyc < scyc + len * CPB - 1) @(negedge clk);
    check("busy_last_stop", {31'b0, busy_w[idx]}, 1);
    @(negedge clk);
    check("busy_end", {31'b0, busy_w[idx]}, 0);
    check("idle_txd", {31'b0, txd[idx]}, 1);
  endtask

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  initial begin
    vec_t        vecs[9];
    logic [8:0]  words[6];
    logic [15:0] bits;
    int          pcyc, scyc, p_first, p6, s_first, prev;

    vecs[0] = '{0, 9'h055, 1'b0, 10};
    vecs[1] = '{1, 9'h007, 1'b1, 11};
    vecs[2] = '{2, 9'h007, 1'b0, 11};
    vecs[3] = '{3, 9'h07F, 1'b0, 10};
    vecs[4] = '{0, 9'h0A3, 1'b0, 10};
    vecs[5] = '{1, 9'h0FF, 1'b0, 11};
    vecs[6] = '{2, 9'h000, 1'b1, 11};
    vecs[7] = '{3, 9'h015, 1'b0, 10};
    vecs[8] = '{1, 9'h080, 1'b1, 11};
    for (int i = 0; i < 4; i++) tdata[i] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_txd%0d", i),   {31'b0, txd[i]}, 1);
      check($sformatf("rst_busy%0d", i),  {31'b0, busy_w[i]}, 0);
      check($sformatf("rst_ready%0d", i), {31'b0, rdy[i]}, 1);
      check($sformatf("rst_cnt%0d", i),   {29'b0, cnt_w[i]}, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames on each configuration.
    for (int i = 0; i < 9; i++) begin
      push_word(vecs[i].idx, vecs[i].data, pcyc);
      tvalid[vecs[i].idx] = 1'b0;
      recv_and_score(vecs[i].idx, bits, scyc);
      check("latency", scyc - pcyc, 1);
      if (f_par(vecs[i].idx) != 0) check("parity", {31'b0, bits[1 + f_db(vecs[i].idx)]}, {31'b0, vecs[i].exp_par});
      check_end(vecs[i].idx, scyc, vecs[i].exp_len);
    end

    // Six words back-to-back into a four-deep FIFO.
    words = '{9'h011, 9'h022, 9'h0C3, 9'h044, 9'h0E5, 9'h066};
    p_first = 0; p6 = 0; s_first = 0; prev = 0;
    fork
      begin
        int p;
        for (int k = 0; k < 6; k++) begin
          push_word(0, words[k], p);
          if (k == 4) begin
            check("cnt_full", {29'b0, cnt_w[0]}, 4);
            check("ready_full", {31'b0, rdy[0]}, 0);
          end
          if (k == 5) p6 = p;
        end
        tvalid[0] = 1'b0;
      end
      begin
        logic [15:0] b;
        int s;
        for (int k = 0; k < 6; k++) begin
          recv_and_score(0, b, s);
          if (k == 0) s_first = s;
          else check("gap", s - prev, 10 * CPB);
          prev = s;
        end
      end
    join
    check("sixth_accept", p6 - s_first, 10 * CPB + 1);
    repeat (4) @(negedge clk);

    // Push and pop on the same edge with two words queued.
    fork
      begin
        int p1, p;
        push_word(0, 9'h0A1, p1);
        push_word(0, 9'h0B2, p);
        push_word(0, 9'h0C3, p);
        tvalid[0] = 1'b0;
        while (cyc < p1 + 10 * CPB) @(negedge clk);
        check("cnt_before_same_edge", {29'b0, cnt_w[0]}, 2);
        push_word(0, 9'h0D4, p);
        tvalid[0] = 1'b0;
        check("same_edge_cyc", p - p1, 10 * CPB + 1);
        check("cnt_after_same_edge", {29'b0, cnt_w[0]}, 2);
      end
      begin
        logic [15:0] b;
        int s, pr;
        pr = 0;
        for (int k = 0; k < 4; k++) begin
          recv_and_score(0, b, s);
          if (k > 0) check("gap2", s - pr, 10 * CPB);
          pr = s;
        end
      end
    join
    repeat (4) @(negedge clk);

    // Reset during data bit 3 with a second word still queued.
    push_word(0, 9'h0C5, pcyc);
    push_word(0, 9'h033, scyc);
    tvalid[0] = 1'b0;
    while (cyc < pcyc + 1 + 4 * CPB + 1) @(negedge clk);
    check("pre_reset_txd", {31'b0, txd[0]}, 0);
    rst_n = 1'b0;
    #1;
    check("reset_txd", {31'b0, txd[0]}, 1);
    check("reset_cnt", {29'b0, cnt_w[0]}, 0);
    check("reset_busy", {31'b0, busy_w[0]}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(0, 9'h096, pcyc);
    tvalid[0] = 1'b0;
    recv_and_score(0, bits, scyc);
    check("post_reset_latency", scyc - pcyc, 1);
    check_end(0, scyc, 10);
    check("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
